// File: rtl/fpu_pkg.sv
// fpu_pkg: fp32 constants, FSM states and the shared
// round/pack helper used by fmul and fadd.
package fpu_pkg;

  localparam logic [31:0] RSQRT_MAGIC = 32'h5F375A86;
  localparam logic [31:0] FP_HALF     = 32'h3F000000;
  localparam logic [31:0] FP_3HALF    = 32'h3FC00000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
  localparam logic [31:0] FP_PINF     = 32'h7F800000;
  localparam logic [31:0] FP_NINF     = 32'hFF800000;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef enum logic [2:0] {
    IDLE, HALF, MUL_YY, MUL_HX,
    SUB, MUL_Y, ROOT, DONE
  } state_e;

  function automatic int cnt_width(input int iters);
    return $clog2(iters + 1);
  endfunction

  // m has its leading one at bit 23; e is the biased exponent of m.
  function automatic logic [31:0] fp_round(
    input logic              s,
    input logic signed [9:0] e,
    input logic [23:0]       m,
    input logic              g,
    input logic              st,
    input logic [2:0]        rm
  );
    logic              up;
    logic              to_max;
    logic [24:0]       mr;
    logic signed [9:0] er;
    unique case (rm)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = s & (g | st);
      RM_RUP:  up = ~s & (g | st);
      RM_RMM:  up = g;
      default: up = g & (st | m[0]);
    endcase
    mr = {1'b0, m} + {24'd0, up};
    er = e;
    if (mr[24]) begin
      mr = mr >> 1;
      er = e + 10'sd1;
    end
    to_max = (rm == RM_RTZ)
           | ((rm == RM_RDN) & ~s)
           | ((rm == RM_RUP) & s);
    if (er >= 10'sd255)
      return to_max ? {s, 31'h7F7FFFFF}
                    : {s, 31'h7F800000};
    else if (er <= 10'sd0)
      return {s, 31'd0};
    else
      return {s, er[7:0], mr[22:0]};
  endfunction

endpackage

// File: rtl/fadd.sv
// fadd: combinational fp32 adder, denormals flushed
// to zero, guard/round/sticky alignment.
module fadd
  import fpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  rm_i,
  output logic [31:0] y_o
);

  logic              a_z, b_z;
  logic              a_inf, b_inf;
  logic              a_nan, b_nan;
  logic              zs;
  logic              sub;
  logic [31:0]       big, sml;
  logic [7:0]        d;
  logic [50:0]       wide;
  logic [26:0]       al;
  logic [27:0]       sum;
  logic [26:0]       nrm;
  logic [4:0]        lz;
  logic signed [9:0] e;

  assign a_z   = a_i[30:23] == 8'd0;
  assign b_z   = b_i[30:23] == 8'd0;
  assign a_inf = (a_i[30:23] == 8'hFF) & ~|a_i[22:0];
  assign b_inf = (b_i[30:23] == 8'hFF) & ~|b_i[22:0];
  assign a_nan = (a_i[30:23] == 8'hFF) & |a_i[22:0];
  assign b_nan = (b_i[30:23] == 8'hFF) & |b_i[22:0];
  assign zs    = (a_i[31] & b_i[31])
               | ((rm_i == RM_RDN) & (a_i[31] | b_i[31]));

  always_comb begin
    big  = (a_i[30:0] < b_i[30:0]) ? b_i : a_i;
    sml  = (a_i[30:0] < b_i[30:0]) ? a_i : b_i;
    sub  = big[31] ^ sml[31];
    d    = big[30:23] - sml[30:23];
    wide = {1'b1, sml[22:0], 27'd0} >> d;
    // bits shifted past the guard/round pair fold into sticky
    al   = (d > 8'd50) ? 27'd1
         : {wide[50:25], wide[24] | (|wide[23:0])};
    sum  = sub ? {2'b01, big[22:0], 3'd0} - {1'b0, al}
               : {2'b01, big[22:0], 3'd0} + {1'b0, al};
    lz   = '0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    if (sum[27]) begin
      nrm = {sum[27:2], sum[1] | sum[0]};
      e   = $signed({2'b0, big[30:23]}) + 10'sd1;
    end else begin
      nrm = sum[26:0] << lz;
      e   = $signed({2'b0, big[30:23]})
          - $signed({5'b0, lz});
    end
    if (a_nan | b_nan | (a_inf & b_inf & (a_i[31] ^ b_i[31])))
      y_o = FP_QNAN;
    else if (a_inf)
      y_o = a_i;
    else if (b_inf)
      y_o = b_i;
    else if (a_z & b_z)
      y_o = {zs, 31'd0};
    else if (a_z)
      y_o = b_i;
    else if (b_z)
      y_o = a_i;
    else if (sum == '0)
      y_o = {rm_i == RM_RDN, 31'd0};
    else
      y_o = fp_round(big[31], e, nrm[26:3], nrm[2],
                     |nrm[1:0], rm_i);
  end

endmodule

// File: rtl/fmul.sv
// fmul: combinational fp32 multiplier, denormals
// flushed to zero, five RISC-V rounding modes.
module fmul
  import fpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  rm_i,
  output logic [31:0] y_o
);

  logic              s;
  logic              a_z, b_z;
  logic              a_inf, b_inf;
  logic              a_nan, b_nan;
  logic [47:0]       p;
  logic [47:0]       pn;
  logic signed [9:0] e;

  assign s     = a_i[31] ^ b_i[31];
  assign a_z   = a_i[30:23] == 8'd0;
  assign b_z   = b_i[30:23] == 8'd0;
  assign a_inf = (a_i[30:23] == 8'hFF) & ~|a_i[22:0];
  assign b_inf = (b_i[30:23] == 8'hFF) & ~|b_i[22:0];
  assign a_nan = (a_i[30:23] == 8'hFF) & |a_i[22:0];
  assign b_nan = (b_i[30:23] == 8'hFF) & |b_i[22:0];

  assign p = {24'd0, 1'b1, a_i[22:0]}
           * {24'd0, 1'b1, b_i[22:0]};

  always_comb begin
    pn = p[47] ? p : {p[46:0], 1'b0};
    e  = $signed({2'b0, a_i[30:23]})
       + $signed({2'b0, b_i[30:23]})
       - 10'sd127
       + (p[47] ? 10'sd1 : 10'sd0);
    if (a_nan | b_nan | (a_inf & b_z) | (b_inf & a_z))
      y_o = FP_QNAN;
    else if (a_inf | b_inf)
      y_o = {s, 31'h7F800000};
    else if (a_z | b_z)
      y_o = {s, 31'd0};
    else
      y_o = fp_round(s, e, pn[47:24], pn[23],
                     |pn[22:0], rm_i);
  end

endmodule

// File: rtl/fsqrt_special.sv
// fsqrt_special: classifies operands that bypass the
// Newton iteration and supplies their final result.
module fsqrt_special
  import fpu_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic        mode_i,
  output logic        is_special_o,
  output logic [31:0] res_o,
  output logic        invalid_o
);

  logic zero, nan, neg_nz, pinf;

  assign zero   = x_i[30:23] == 8'd0;
  assign nan    = (x_i[30:23] == 8'hFF) & |x_i[22:0];
  assign neg_nz = x_i[31] & ~zero & ~nan;
  assign pinf   = ~x_i[31] & (x_i[30:0] == 31'h7F800000);

  always_comb begin
    is_special_o = 1'b1;
    res_o        = FP_QNAN;
    invalid_o    = 1'b0;
    unique case (1'b1)
      nan:     invalid_o = ~x_i[22];
      zero:    res_o = mode_i ? {x_i[31], 31'd0}
                              : (x_i[31] ? FP_NINF : FP_PINF);
      neg_nz:  invalid_o = 1'b1;
      pinf:    res_o = mode_i ? FP_PINF : 32'd0;
      default: is_special_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fsqrt_iter.sv
// fsqrt_iter: iterative fp32 rsqrt/sqrt via Newton steps.
// FSQRT_SPECIAL_CASE_EN enables the special-operand bypass.
module fsqrt_iter
  import fpu_pkg::*;
#(
  parameter int NEWTON_ITERS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] num,
  input  logic        mode,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        invalid
);

  localparam int CW = cnt_width(NEWTON_ITERS);

  state_e          state_q, state_d;
  logic [31:0]     x_q, x_d;
  logic [31:0]     hx_q, hx_d;
  logic [31:0]     y_q, y_d;
  logic [31:0]     t_q, t_d;
  logic            mode_q, mode_d;
  logic [2:0]      rm_q, rm_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            inv_q, inv_d;
  logic            acc;
  logic [31:0]     ma, mb, mr, ar;
  logic            sp_hit, sp_inv;
  logic [31:0]     sp_res;

`ifdef FSQRT_SPECIAL_CASE_EN
  fsqrt_special u_special (
    .x_i          (num),
    .mode_i       (mode),
    .is_special_o (sp_hit),
    .res_o        (sp_res),
    .invalid_o    (sp_inv)
  );
  assign invalid = inv_q;
`else
  assign sp_hit  = 1'b0;
  assign sp_res  = '0;
  assign sp_inv  = 1'b0;
  assign invalid = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign acc       = in_valid & in_ready;
  assign out_valid = state_q == DONE;
  assign result    = y_q;

  always_comb begin
    ma = y_q;
    mb = y_q;
    unique case (state_q)
      HALF:    begin ma = x_q; mb = FP_HALF; end
      MUL_HX:  begin ma = t_q; mb = hx_q;    end
      MUL_Y:   begin ma = y_q; mb = t_q;     end
      ROOT:    begin ma = x_q; mb = y_q;     end
      default: ;
    endcase
  end

  fmul u_mul (
    .a_i  (ma),
    .b_i  (mb),
    .rm_i (rm_q),
    .y_o  (mr)
  );

  // 1.5 - t computed as 1.5 + (-t)
  fadd u_add (
    .a_i  (FP_3HALF),
    .b_i  ({~t_q[31], t_q[30:0]}),
    .rm_i (rm_q),
    .y_o  (ar)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    hx_d    = hx_q;
    y_d     = y_q;
    t_d     = t_q;
    mode_d  = mode_q;
    rm_d    = rm_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    unique case (state_q)
      IDLE: if (acc) begin
        x_d     = num;
        mode_d  = mode;
        rm_d    = rm;
        cnt_d   = '0;
        inv_d   = sp_inv;
        y_d     = sp_hit ? sp_res
                         : RSQRT_MAGIC - {1'b0, num[31:1]};
        state_d = sp_hit ? DONE : HALF;
      end
      HALF: begin
        hx_d    = mr;
        state_d = MUL_YY;
      end
      MUL_YY: begin
        t_d     = mr;
        state_d = MUL_HX;
      end
      MUL_HX: begin
        t_d     = mr;
        state_d = SUB;
      end
      SUB: begin
        t_d     = ar;
        state_d = MUL_Y;
      end
      MUL_Y: begin
        y_d   = mr;
        cnt_d = cnt_q + 1'b1;
        if (int'(cnt_q) + 1 < NEWTON_ITERS)
          state_d = MUL_YY;
        else
          state_d = mode_q ? ROOT : DONE;
      end
      ROOT: begin
        y_d     = mr;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      hx_q    <= '0;
      y_q     <= '0;
      t_q     <= '0;
      mode_q  <= 1'b0;
      rm_q    <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      hx_q    <= hx_d;
      y_q     <= y_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
      rm_q    <= rm_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
    end
  end

endmodule

// File: doc/fsqrt_iter.md
# fsqrt_iter

Iterative, handshaked IEEE-754 single-precision square-root / reciprocal-square-root unit for the FPU. A magic-constant seed is refined by a parameterised number of Newton steps. Each step is y = y·(1.5 − 0.5·x·y²). One shared `fmul` and one shared `fadd` are time-multiplexed across the steps. The unit sits beside the other FPU operators behind a valid/ready interface and adds a sqrt mode, special-operand handling and back-pressure.

## Interface
- `NEWTON_ITERS`, default 2: Newton steps per operation, legal range 1..7.
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `in_valid`  in  1  operand offered
- `in_ready`  out  1  unit can accept an operand
- `num`  in  32  operand x
- `mode`  in  1  0 = 1/√x, 1 = √x; sampled on acceptance
- `rm`  in  3  rounding mode for `fmul`/`fadd`; sampled on acceptance
- `out_valid`  out  1  result held
- `out_ready`  in  1  consumer takes result
- `result`  out  32  result
- `invalid`  out  1  invalid-operation flag; qualified by `out_valid`

## Operation
- States: IDLE, HALF, MUL_YY, MUL_HX, SUB, MUL_Y, ROOT, DONE.
- IDLE
  - `in_ready` = 1.
  - Acceptance happens on `in_valid & in_ready`.
  - On acceptance, register x, mode and rm.
  - Register the seed y0 = 0x5F375A86 − (x >> 1).
  - Clear the iteration counter and go to HALF.
- HALF: hx = 0.5·x.
- Each Newton step runs MUL_YY → MUL_HX → SUB → MUL_Y:
  - MUL_YY: t = y·y.
  - MUL_HX: t = t·hx.
  - SUB: t = 1.5 + (−t), by sign-flipping t into `fadd`.
  - MUL_Y: y = y·t, then increment the counter.
- After MUL_Y:
  - Counter < NEWTON_ITERS → MUL_YY.
  - Otherwise mode = 1 → ROOT, mode = 0 → DONE.
- ROOT: y = x·y.
- DONE
  - `out_valid` = 1; `result` and `invalid` are stable.
  - When `out_ready` = 1, go to IDLE.
  - No new operand is accepted in the same cycle as the output is taken.
- Exactly one `fmul` or `fadd` result is registered per state. All intermediates are 32-bit fp registers.
- Constants: 0.5 = 0x3F000000, 1.5 = 0x3FC00000, canonical qNaN = 0x7FC00000.

## Timing
- Reset values: `in_ready` 0 while `rst` is high; state IDLE; `out_valid` 0; `result` 0; `invalid` 0; counter 0.
- `in_ready` reads 1 from the first cycle after `rst` falls.
- Latency for normal operands, counted from the accepting edge to the edge that raises `out_valid`: L = 2 + 4·NEWTON_ITERS + mode.
  - NEWTON_ITERS = 2: L = 10 for 1/√x, 11 for √x.
- Throughput: one operation per L + 1 cycles when `out_ready` is tied high.
- `in_ready` is 0 in every state except IDLE.
- `out_valid` is held with unchanged data until taken. There is no drop and no overwrite.
- `rst` asserted mid-operation aborts on the next edge: back to IDLE, outputs to their reset values, the operation is lost.
- `rm`/`mode` changes after acceptance have no effect.

## Configuration
- Macro `FSQRT_SPECIAL_CASE_EN`.
- Defined: special operands are decoded at acceptance and go directly to DONE, giving L = 1:
  - x < 0 (non-zero), or NaN: result 0x7FC00000, `invalid` = 1 only for negative non-NaN and sNaN.
  - +0: 1/√x → 0x7F800000, √x → 0x00000000.
  - −0: 1/√x → 0xFF800000, √x → 0x80000000.
  - +inf: 1/√x → 0x00000000, √x → 0x7F800000.
  - Denormals are flushed to the matching-sign zero first.
- Undefined:
  - All operands take the iterative path.
  - `invalid` is tied to 0.
  - Results for special operands are unspecified.
  - The decoder sub-module is not instantiated.

## Structure
- `fpu_pkg` holds:
  - the magic constant 0x5F375A86;
  - the fp constants 0.5, 1.5, qNaN and ±inf;
  - the state enum;
  - the counter width, $clog2(NEWTON_ITERS+1).
- Sub-module `fsqrt_special`: combinational classifier producing `is_special`, the special result and `invalid`. It is only instantiated under `FSQRT_SPECIAL_CASE_EN`.
- The existing `fmul` and `fadd` are each instantiated once. Operand muxes are selected by state.

## Test plan
- x = 0x40800000 (4.0), mode 0, NEWTON_ITERS = 2 → `out_valid` exactly 10 cycles after acceptance; result within 1e-5 relative of 0x3F000000 (0.5); `invalid` = 0.
- x = 0x40800000, mode 1 → 11 cycles; result within 1e-5 relative of 0x40000000 (2.0).
- `out_ready` held 0 for 5 cycles after `out_valid` → `result` stable and `in_ready` = 0 throughout; a new `in_valid` is ignored until one cycle after the handshake.
- With `FSQRT_SPECIAL_CASE_EN`: x = 0xC0800000 (−4.0) → 0x7FC00000, `invalid` = 1, L = 1. x = 0x00000000, mode 0 → 0x7F800000.
- `rst` pulsed in the MUL_HX state of step 1 → next cycle IDLE, `out_valid` 0; the following operand 0x41100000 (9.0), mode 1 → ≈0x40400000 (3.0) with nominal latency.
- Sweep of 1000 random positive normals per mode → relative error below 1e-5; all latencies equal L.
